// File: rtl/dm_responder.sv
// Slow data-memory responder: byte/half/word loads and stores on a word array, with fixed wait states and a one-cycle MIO_ready pulse.
// Optional DM_MISALIGN_TRAP_EN: misaligned word/half accesses are suppressed and flagged on misalign_err.
module dm_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  DMType,
  output logic [31:0] dout,
  output logic        MIO_ready,
  output logic        misalign_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] LAST_CNT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            lat_store;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     lat_din;
  logic [2:0]      lat_type;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            in_idle;
  logic            req;
  logic            enter_resp;
  logic            cur_store;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_din;
  logic [2:0]      cur_type;
  logic [1:0]      lane;
  logic            is_half;
  logic            is_byte;
  logic            is_signed;
  logic            cur_mis;
  logic [31:0]     rword;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [31:0]     ld_val;
  logic [31:0]     wdata;
  logic [3:0]      wmask;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AW+2];

  assign in_idle = (state == IDLE);
  assign req     = mem_r | mem_w;

  // In IDLE the access is decoded straight from the inputs so a zero-wait
  // configuration can complete on the accepting edge.
  assign cur_store = in_idle ? mem_w            : lat_store;
  assign cur_addr  = in_idle ? addr[AW+1:0]     : lat_addr;
  assign cur_din   = in_idle ? din              : lat_din;
  assign cur_type  = in_idle ? DMType           : lat_type;

  assign enter_resp = (in_idle && req && NO_WAIT) ||
                      (state == WAIT && wait_cnt == LAST_CNT);

  assign lane      = cur_addr[1:0];
  assign is_half   = (cur_type == 3'b001) || (cur_type == 3'b010);
  assign is_byte   = (cur_type == 3'b011) || (cur_type == 3'b100);
  assign is_signed = (cur_type == 3'b001) || (cur_type == 3'b011);

`ifdef DM_MISALIGN_TRAP_EN
  assign cur_mis = (!is_half && !is_byte && lane != 2'b00) || (is_half && lane[0]);
`else
  assign cur_mis = 1'b0;
`endif

  assign rword = mem[cur_addr[AW+1:2]];
  assign bsel  = rword[{lane, 3'b000} +: 8];
  assign hsel  = lane[1] ? rword[31:16] : rword[15:0];

  // Store data is replicated across lanes; the mask picks which lanes land.
  always_comb begin
    wdata  = cur_din;
    wmask  = 4'hF;
    ld_val = rword;
    if (is_byte) begin
      wdata  = {4{cur_din[7:0]}};
      wmask  = 4'b0001 << lane;
      ld_val = is_signed ? {{24{bsel[7]}}, bsel} : {24'b0, bsel};
    end else if (is_half) begin
      wdata  = {2{cur_din[15:0]}};
      wmask  = lane[1] ? 4'b1100 : 4'b0011;
      ld_val = is_signed ? {{16{hsel[15]}}, hsel} : {16'b0, hsel};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_store && !cur_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[cur_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      MIO_ready    <= 1'b0;
      dout         <= 32'd0;
      misalign_err <= 1'b0;
      lat_store    <= 1'b0;
      lat_addr     <= '0;
      lat_din      <= 32'd0;
      lat_type     <= 3'd0;
    end else begin
      if (enter_resp) begin
        MIO_ready    <= 1'b1;
        misalign_err <= cur_mis;
        dout         <= (cur_store || cur_mis) ? 32'd0 : ld_val;
      end
      case (state)
        IDLE: begin
          if (req) begin
            lat_store <= mem_w;
            lat_addr  <= addr[AW+1:0];
            lat_din   <= din;
            lat_type  <= DMType;
            state     <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAST_CNT) begin
            wait_cnt <= 4'd0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          MIO_ready    <= 1'b0;
          misalign_err <= 1'b0;
          dout         <= 32'd0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: byte-addressed reference model, directed cases and random traffic.
// A second zero-wait instance shares the inputs to exercise back-to-back completion and address aliasing.
module tb_dm_responder;

  localparam int DEPTH = 128;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_r, mem_w;
  logic [31:0] addr, din;
  logic [2:0]  DMType;
  logic [31:0] dout, dout0;
  logic        MIO_ready, ready0;
  logic        misalign_err, mis0;

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .addr(addr), .din(din),
    .DMType(DMType), .dout(dout), .MIO_ready(MIO_ready), .misalign_err(misalign_err)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .addr(addr), .din(din),
    .DMType(DMType), .dout(dout0), .MIO_ready(ready0), .misalign_err(mis0)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [7:0]  mb [DEPTH*4];
  logic [31:0] last_dout;
  logic        last_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array indexed modulo its size.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, output logic [31:0] ed, output logic em);
    int sz;
    int base;
    logic [31:0] v;
    sz   = (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 4;
    base = int'(a % (DEPTH*4));
    em   = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
    em = (base % sz) != 0;
`endif
    base = base - (base % sz);
    v = 32'd0;
    if (!em) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mb[base+i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[base+i];
        if (t == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
        if (t == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
      end
    end
    ed = (w || em) ? 32'd0 : v;
  endtask

  task automatic run(input string tag, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] t);
    logic [31:0] ed;
    logic em;
    bit got;
    int lat;
    got = 0;
    lat = 0;
    @(negedge clk);
    mem_r = r; mem_w = w; addr = a; din = d; DMType = t;
    model(w, a, d, t, ed, em);
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (MIO_ready === 1'b1) begin
        got = 1;
        last_dout = dout;
        last_mis = misalign_err;
      end
    end
    mem_r = 1'b0; mem_w = 1'b0;
    chk({tag, " timeout"}, 32'(got), 32'd1);
    chk({tag, " latency"}, lat, WC + 1);
    chk({tag, " dout"}, last_dout, ed);
    chk({tag, " misalign"}, 32'(last_mis), 32'(em));
    @(posedge clk); #1;
    chk({tag, " ready drop"}, 32'(MIO_ready), 32'd0);
    chk({tag, " dout clear"}, dout, 32'd0);
  endtask

  initial begin
    logic [2:0]  rt;
    logic [31:0] ra;
    logic        rw, rr;
    logic [31:0] ew;
    bit          seen;

    reset = 1'b1; mem_r = 1'b0; mem_w = 1'b0; addr = '0; din = '0; DMType = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(MIO_ready), 32'd0);
    chk("reset dout", dout, 32'd0);
    chk("reset misalign", 32'(misalign_err), 32'd0);
    chk("reset ready0", 32'(ready0), 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) run("init", 1'b0, 1'b1, 32'(i*4), $urandom, 3'd0);

    run("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
    run("lw10", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
    chk("t1 lw", last_dout, 32'hDEADBEEF);
    run("sb11", 1'b0, 1'b1, 32'h11, 32'h5A5A5AAA, 3'd3);
    run("lw10b", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
    chk("t2 lw", last_dout, 32'hDEADAAEF);
    run("lb11", 1'b1, 1'b0, 32'h11, 32'h0, 3'd3);
    chk("t2 lb", last_dout, 32'hFFFFFFAA);
    run("lbu11", 1'b1, 1'b0, 32'h11, 32'h0, 3'd4);
    chk("t2 lbu", last_dout, 32'h000000AA);
    run("lh12", 1'b1, 1'b0, 32'h12, 32'h0, 3'd1);
    chk("t3 lh", last_dout, 32'hFFFFDEAD);
    run("lhu12", 1'b1, 1'b0, 32'h12, 32'h0, 3'd2);
    chk("t3 lhu", last_dout, 32'h0000DEAD);
    run("sh12", 1'b0, 1'b1, 32'h12, 32'hABCD1234, 3'd1);
    run("lw10c", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
    chk("t3 lw", last_dout, 32'h1234AAEF);

    run("lw13", 1'b1, 1'b0, 32'h13, 32'h0, 3'd0);
`ifdef DM_MISALIGN_TRAP_EN
    chk("t4 mis lw dout", last_dout, 32'h0);
    chk("t4 mis lw flag", 32'(last_mis), 32'd1);
`else
    chk("t4 lw13 dout", last_dout, 32'h1234AAEF);
    chk("t4 lw13 flag", 32'(last_mis), 32'd0);
`endif
    run("sw12", 1'b0, 1'b1, 32'h12, 32'h0, 3'd0);
    run("lw10d", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0);
`ifdef DM_MISALIGN_TRAP_EN
    chk("t4 sw12 dropped", last_dout, 32'h1234AAEF);
`else
    chk("t4 sw12 aligned", last_dout, 32'h0);
`endif

    // Reset mid-access must drop the pending store and suppress the pulse.
    run("sw20", 1'b0, 1'b1, 32'h20, 32'h11223344, 3'd0);
    @(negedge clk);
    mem_w = 1'b1; addr = 32'h20; din = 32'h55; DMType = 3'd0;
    @(posedge clk); #1;
    reset = 1'b1; mem_w = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (MIO_ready !== 1'b0) seen = 1;
    end
    @(negedge clk) reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (MIO_ready !== 1'b0) seen = 1;
    end
    chk("t5 no ready on reset", 32'(seen), 32'd0);
    run("lw20", 1'b1, 1'b0, 32'h20, 32'h0, 3'd0);
    chk("t5 store dropped", last_dout, 32'h11223344);
    run("rw24", 1'b1, 1'b1, 32'h24, 32'h77, 3'd0);
    chk("t5 rw dout", last_dout, 32'h0);
    run("lw24", 1'b1, 1'b0, 32'h24, 32'h0, 3'd0);
    chk("t5 rw stored", last_dout, 32'h77);

    repeat (150) begin
      rt = 3'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 1023));
      rw = 1'($urandom_range(0, 1));
      rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
      run("rnd", rr, rw, ra, $urandom, rt);
    end

    // Zero-wait instance: held load completes every second cycle, 0x200 aliases word 0.
    ew = {mb[3], mb[2], mb[1], mb[0]};
    @(negedge clk);
    mem_r = 1'b1; mem_w = 1'b0; addr = 32'h200; DMType = 3'd0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("t6 b2b ready", 32'(ready0), 32'((k % 2) == 0));
      if ((k % 2) == 0) chk("t6 alias dout", dout0, ew);
    end
    mem_r = 1'b0;
    repeat (8) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
